risc_v_mike_wb_arbiter: RTL

//  Write-side master for the integer register file: merges ALU (single-cycle) and LSU/long-latency results onto the

---
 rtl/risc_v_mike_pkg.sv | 19 +
 rtl/risc_v_mike_wb_fifo.sv | 63 ++++++
 rtl/risc_v_mike_wb_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/risc_v_mike_pkg.sv
// Shared types for the risc_v_mike integer pipeline: register index, datapath width
// and the write-back request carried from the LSU path to the register file.
package risc_v_mike_pkg;

    localparam int DATA_32_W   = 32;
    localparam int INSTR_REG_W = 5;

    typedef logic [INSTR_REG_W-1:0] t_instr_register;

    typedef struct packed {
        t_instr_register       addr;
        logic [DATA_32_W-1:0]  data;
    } t_wb_req;

    function automatic logic is_x0(input t_instr_register addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/risc_v_mike_wb_fifo.sv
// Small in-order buffer for LSU write-back requests. A push into a full FIFO
// is dropped even when a pop happens the same cycle; callers gate on !full.
module risc_v_mike_wb_fifo
    import risc_v_mike_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  t_wb_req                 push_data,
    input  logic                    pop,
    output t_wb_req                 head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    t_wb_req            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               do_push;
    logic               do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Storage needs no reset: entries are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/risc_v_mike_wb_arbiter.sv
// Register-file write-port master: ALU results win, buffered LSU results fill the gaps,
// and busy_vec tracks destinations of long-latency ops still in flight.
module risc_v_mike_wb_arbiter
    import risc_v_mike_pkg::*;
#(
    parameter int REG_FILE_DEPTH = 16,
    parameter int WB_FIFO_DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_wb_valid,
    input  t_instr_register            alu_wb_addr,
    input  logic [DATA_32_W-1:0]       alu_wb_data,
    input  logic                       lsu_wb_valid,
    output logic                       lsu_wb_ready,
    input  t_instr_register            lsu_wb_addr,
    input  logic [DATA_32_W-1:0]       lsu_wb_data,
    input  logic                       issue_valid,
    input  t_instr_register            issue_addr,
    output logic [REG_FILE_DEPTH-1:0]  busy_vec,
    output logic                       reg_file_write,
    output t_instr_register            reg_file_wr_addr,
    output logic [DATA_32_W-1:0]       reg_file_wr_data
);

    localparam logic [REG_FILE_DEPTH-1:0] ONE_HOT_X0 = REG_FILE_DEPTH'(1);

    function automatic logic [REG_FILE_DEPTH-1:0] reg_bit(input t_instr_register addr);
        logic [REG_FILE_DEPTH-1:0] v;
        v = '0;
        if (!is_x0(addr) && int'(addr) < REG_FILE_DEPTH) begin
            v = ONE_HOT_X0 << addr;
        end
        return v;
    endfunction

    t_wb_req                      lsu_req;
    t_wb_req                      head;
    t_wb_req                      sel_req;
    logic                         sel_valid;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic [$clog2(WB_FIFO_DEPTH):0] fifo_count;
    logic                         run_q;
    logic [REG_FILE_DEPTH-1:0]    set_mask;
    logic [REG_FILE_DEPTH-1:0]    clr_mask;

    assign lsu_req      = '{addr: lsu_wb_addr, data: lsu_wb_data};
    assign lsu_wb_ready = run_q && !fifo_full;
    assign fifo_push    = lsu_wb_valid && lsu_wb_ready;
    assign fifo_pop     = !alu_wb_valid && !fifo_empty;

    risc_v_mike_wb_fifo #(
        .DEPTH (WB_FIFO_DEPTH)
    ) u_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (lsu_req),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        sel_valid = alu_wb_valid || fifo_pop;
        sel_req   = alu_wb_valid ? '{addr: alu_wb_addr, data: alu_wb_data} : head;
        set_mask  = issue_valid ? reg_bit(issue_addr) : '0;
        clr_mask  = fifo_pop ? reg_bit(head.addr) : '0;
    end

    // run_q keeps ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q            <= 1'b0;
            reg_file_write   <= 1'b0;
            reg_file_wr_addr <= '0;
            reg_file_wr_data <= '0;
            busy_vec         <= '0;
        end else begin
            run_q          <= 1'b1;
            reg_file_write <= sel_valid && !is_x0(sel_req.addr);
            if (sel_valid && !is_x0(sel_req.addr)) begin
                reg_file_wr_addr <= sel_req.addr;
                reg_file_wr_data <= sel_req.data;
            end
            // Set is applied after clear so a re-issue beats the retiring write.
            busy_vec <= ((busy_vec & ~clr_mask) | set_mask) & ~ONE_HOT_X0;
        end
    end

    a_issue_not_busy: assert property (@(posedge clk) disable iff (!rst)
        issue_valid && !is_x0(issue_addr)
        |-> ((busy_vec & reg_bit(issue_addr)) == '0) || (fifo_pop && head.addr == issue_addr));

    a_push_is_busy: assert property (@(posedge clk) disable iff (!rst)
        fifo_push && !is_x0(lsu_wb_addr) |-> (busy_vec & reg_bit(lsu_wb_addr)) != '0);

    a_alu_addr_range: assert property (@(posedge clk) disable iff (!rst)
        alu_wb_valid |-> int'(alu_wb_addr) < REG_FILE_DEPTH);

    a_lsu_addr_range: assert property (@(posedge clk) disable iff (!rst)
        lsu_wb_valid |-> int'(lsu_wb_addr) < REG_FILE_DEPTH);

    a_fifo_count: assert property (@(posedge clk) disable iff (!rst)
        int'(fifo_count) <= WB_FIFO_DEPTH);

endmodule
